// File: rtl/mux_n_pipe_pkg.sv
// Shared constants and helpers for the N-way select pipeline.
package mux_pkg;
    localparam int MAX_NSRC = 16;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mux_n_pipe_if.sv
// Bus bundle between the upstream producer, the select pipeline and the downstream consumer.
interface mux_n_pipe_if #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 3
);
    import mux_pkg::*;
    localparam int SELW = sel_width(NSRC);

    // Handshake: a beat transfers on a rising clk edge where valid & ready are both 1.
    // A producer holding valid high keeps its payload stable until that edge; ready never
    // depends combinationally on valid on the same side.
    logic [NSRC*WIDTH-1:0] src;
    logic [SELW-1:0]       sel;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      rlt;
    logic [SELW-1:0]       sel_q;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output src, sel, in_valid, out_ready,
        input  in_ready, rlt, sel_q, out_valid
    );

    modport slave (
        input  src, sel, in_valid, out_ready,
        output in_ready, rlt, sel_q, out_valid
    );
endinterface

// File: rtl/mux_n_pipe_mux_n.sv
// Combinational N-way select; any index past the last source falls back to the last source.
module mux_n
    import mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NSRC  = 3
) (
    input  logic [NSRC*WIDTH-1:0]       src,
    input  logic [sel_width(NSRC)-1:0]  sel,
    output logic [WIDTH-1:0]            dout
);
    always_comb begin
        dout = src[(NSRC-1)*WIDTH +: WIDTH];
        for (int k = 0; k < NSRC - 1; k++) begin
            if (int'(sel) == k) begin
                dout = src[k*WIDTH +: WIDTH];
            end
        end
    end
endmodule

// File: rtl/mux_n_pipe.sv
// Registered N-way select with valid/ready flow control and a 2-entry (main + skid) buffer.
module mux_n_pipe
    import mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NSRC  = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    mux_n_pipe_if.slave  bus
);
    localparam int SELW = sel_width(NSRC);

    if (NSRC < 2 || NSRC > MAX_NSRC) begin : g_bad_nsrc
        $error("mux_n_pipe: NSRC out of range 2..16");
    end

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SELW-1:0]  sel;
    } entry_t;

    logic [WIDTH-1:0] sel_data;
    entry_t           new_entry;
    entry_t           main_q, main_d;
    entry_t           skid_q, skid_d;
    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             accept, emit;

    mux_n #(
        .WIDTH (WIDTH),
        .NSRC  (NSRC)
    ) u_mux (
        .src  (bus.src),
        .sel  (bus.sel),
        .dout (sel_data)
    );

    assign new_entry = '{data: sel_data, sel: bus.sel};
    assign accept    = bus.in_valid & in_ready_q;
    assign emit      = main_valid_q & bus.out_ready;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (emit) begin
            // accept cannot coincide with a skid drain: in_ready is low while skid is full
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = new_entry;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_q) begin
                main_d       = new_entry;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = new_entry;
                skid_valid_d = 1'b1;
            end
        end
        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = main_valid_q;
    assign bus.rlt       = main_q.data;
    assign bus.sel_q     = main_q.sel;
endmodule
